// File: rtl/mbz_err_seq.sv
// rtl/mbz_err_seq.sv - core request sequencer with NXM timeout and held error address register
// Optional build macro MBZ_ERR_COUNT_EN adds the saturating err_count output.
module mbz_err_seq #(
    parameter int NREQ      = 4,
    parameter int ADR_W     = 22,
    parameter int NXM_CNT_W = 8,
    parameter int NXM_LIMIT = 200,
    parameter int NXM_TAIL  = 4,
    localparam int SRC_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             mem_start,
    input  logic [SRC_W-1:0] req_src,
    input  logic             req_rd,
    input  logic             req_wr,
    input  logic [ADR_W-1:0] req_adr,
    input  logic             ackn_pulse,
    input  logic             mem_data_val,
    input  logic             mb_par_odd,
    input  logic             mem_adr_par_err,
    input  logic             sbus_err_in,
    input  logic             err_clr,
    output logic             core_busy,
    output logic             nxm_ack,
    output logic             nxm_data_val,
    output logic             rd_pse_wr,
    output logic             nxm_err,
    output logic             par_err,
    output logic             adr_par_err,
    output logic             sbus_err,
    output logic [NREQ-1:0]  req_err,
    output logic [ADR_W-1:0] era_adr,
    output logic [SRC_W-1:0] era_src,
    output logic             era_wr,
    output logic             err_hold
`ifdef MBZ_ERR_COUNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_WAIT_DATA,
        S_WAIT_WR,
        S_NXM_T1,
        S_NXM_TAIL
    } state_t;

    state_t               state_q, state_d;
    logic [NXM_CNT_W-1:0] cnt_q, cnt_d;
    logic [SRC_W-1:0]     src_q, src_d;
    logic [ADR_W-1:0]     adr_q, adr_d;
    logic                 rd_q, rd_d, wr_q, wr_d;
    logic                 rpw_q, rpw_d;
    logic                 ndv_q, ndv_d;
    logic                 nxm_ev, par_ev, apar_ev, any_ev;

    logic                 nxm_err_q, nxm_err_d, par_err_q, par_err_d;
    logic                 apar_q, apar_d, sbus_q, sbus_d, hold_q, hold_d;
    logic [NREQ-1:0]      req_err_q, req_err_d, src_oh;
    logic [ADR_W-1:0]     era_adr_q, era_adr_d;
    logic [SRC_W-1:0]     era_src_q, era_src_d;
    logic                 era_wr_q, era_wr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        adr_d   = adr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rpw_d   = rpw_q;
        nxm_ev  = 1'b0;
        par_ev  = 1'b0;
        apar_ev = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_start) begin
                    src_d   = req_src;
                    adr_d   = req_adr;
                    rd_d    = req_rd;
                    wr_d    = req_wr;
                    cnt_d   = '0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // An acknowledge in the timeout cycle still wins over NXM.
                if (ackn_pulse) begin
                    cnt_d   = '0;
                    apar_ev = mem_adr_par_err;
                    rpw_d   = 1'b0;
                    if (rd_q) begin
                        state_d = S_WAIT_DATA;
                    end else begin
                        par_ev  = ~mb_par_odd;
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == NXM_CNT_W'(NXM_LIMIT - 1)) begin
                    rpw_d   = 1'b0;
                    state_d = S_NXM_T1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DATA: begin
                if (mem_data_val) begin
                    par_ev = ~mb_par_odd;
                    if (rd_q && wr_q) begin
                        rpw_d   = 1'b1;
                        state_d = S_WAIT_WR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_WR: begin
                // Write half of read-pause-write keeps the original source and address.
                if (mem_start) begin
                    rd_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_NXM_T1: begin
                nxm_ev  = 1'b1;
                cnt_d   = '0;
                state_d = S_NXM_TAIL;
            end
            S_NXM_TAIL: begin
                if (cnt_q == NXM_CNT_W'(NXM_TAIL - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ndv_d = (state_q == S_NXM_T1) && rd_q;
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            src_oh[i] = (src_q == SRC_W'(i));
        end
        any_ev      = nxm_ev | par_ev | apar_ev;
        nxm_err_d   = (nxm_err_q & ~err_clr) | nxm_ev;
        par_err_d   = (par_err_q & ~err_clr) | par_ev;
        apar_d      = (apar_q & ~err_clr) | apar_ev;
        sbus_d      = (sbus_q & ~err_clr) | sbus_err_in;
        req_err_d   = (err_clr ? '0 : req_err_q) | (any_ev ? src_oh : '0);
        hold_d      = (hold_q & ~err_clr) | any_ev;
        era_adr_d   = era_adr_q;
        era_src_d   = era_src_q;
        era_wr_d    = era_wr_q;
        // A clear in the same cycle as a new error re-arms capture for that error.
        if (any_ev && (!hold_q || err_clr)) begin
            era_adr_d = adr_q;
            era_src_d = src_q;
            era_wr_d  = ~rd_q;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            src_q     <= '0;
            adr_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rpw_q     <= 1'b0;
            ndv_q     <= 1'b0;
            nxm_err_q <= 1'b0;
            par_err_q <= 1'b0;
            apar_q    <= 1'b0;
            sbus_q    <= 1'b0;
            hold_q    <= 1'b0;
            req_err_q <= '0;
            era_adr_q <= '0;
            era_src_q <= '0;
            era_wr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            src_q     <= src_d;
            adr_q     <= adr_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            rpw_q     <= rpw_d;
            ndv_q     <= ndv_d;
            nxm_err_q <= nxm_err_d;
            par_err_q <= par_err_d;
            apar_q    <= apar_d;
            sbus_q    <= sbus_d;
            hold_q    <= hold_d;
            req_err_q <= req_err_d;
            era_adr_q <= era_adr_d;
            era_src_q <= era_src_d;
            era_wr_q  <= era_wr_d;
        end
    end

`ifdef MBZ_ERR_COUNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = any_ev ? 8'd1 : 8'd0;
        end else if (any_ev && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

    assign core_busy    = (state_q != S_IDLE) && (state_q != S_WAIT_WR);
    assign nxm_ack      = (state_q == S_NXM_T1);
    assign nxm_data_val = ndv_q;
    assign rd_pse_wr    = rpw_q;
    assign nxm_err      = nxm_err_q;
    assign par_err      = par_err_q;
    assign adr_par_err  = apar_q;
    assign sbus_err     = sbus_q;
    assign req_err      = req_err_q;
    assign era_adr      = era_adr_q;
    assign era_src      = era_src_q;
    assign era_wr       = era_wr_q;
    assign err_hold     = hold_q;

endmodule

// File: tb/tb_mbz_err_seq.sv
// tb/tb_mbz_err_seq.sv - scoreboard bench for mbz_err_seq
module tb_mbz_err_seq;
    localparam int NREQ = 4;
    localparam int ADR_W = 22;
    localparam int LIM = 200;
    localparam int TAIL = 4;

    logic clk = 1'b0;
    logic RESET, mem_start, req_rd, req_wr, ackn_pulse, mem_data_val;
    logic mb_par_odd, mem_adr_par_err, sbus_err_in, err_clr;
    logic [1:0] req_src;
    logic [ADR_W-1:0] req_adr;
    logic core_busy, nxm_ack, nxm_data_val, rd_pse_wr, nxm_err, par_err;
    logic adr_par_err, sbus_err, era_wr, err_hold;
    logic [NREQ-1:0] req_err;
    logic [ADR_W-1:0] era_adr;
    logic [1:0] era_src;

    always #5 clk = ~clk;

    mbz_err_seq #(.NREQ(NREQ), .ADR_W(ADR_W), .NXM_CNT_W(8), .NXM_LIMIT(LIM), .NXM_TAIL(TAIL)) dut (
        .clk(clk), .RESET(RESET), .mem_start(mem_start), .req_src(req_src),
        .req_rd(req_rd), .req_wr(req_wr), .req_adr(req_adr), .ackn_pulse(ackn_pulse),
        .mem_data_val(mem_data_val), .mb_par_odd(mb_par_odd), .mem_adr_par_err(mem_adr_par_err),
        .sbus_err_in(sbus_err_in), .err_clr(err_clr), .core_busy(core_busy), .nxm_ack(nxm_ack),
        .nxm_data_val(nxm_data_val), .rd_pse_wr(rd_pse_wr), .nxm_err(nxm_err), .par_err(par_err),
        .adr_par_err(adr_par_err), .sbus_err(sbus_err), .req_err(req_err), .era_adr(era_adr),
        .era_src(era_src), .era_wr(era_wr), .err_hold(err_hold)
    );

    typedef struct {
        int busy_len;
        logic nxm, par, apar, rpw, hold, ewr;
        logic [3:0] rerr;
        logic [ADR_W-1:0] eadr;
        logic [1:0] esrc;
    } exp_t;

    exp_t sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic m_nxm, m_par, m_apar, m_hold, m_ewr;
    logic [3:0] m_rerr;
    logic [ADR_W-1:0] m_eadr;
    logic [1:0] m_esrc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_clear();
        m_nxm = 0; m_par = 0; m_apar = 0; m_hold = 0; m_rerr = '0;
    endfunction

    function automatic void m_err(input int kind, input logic [1:0] s, input logic [ADR_W-1:0] a, input logic w);
        if (kind == 0) m_nxm = 1;
        else if (kind == 1) m_par = 1;
        else m_apar = 1;
        m_rerr[s] = 1'b1;
        if (!m_hold) begin
            m_eadr = a; m_esrc = s; m_ewr = w; m_hold = 1;
        end
    endfunction

    function automatic void push(input int len, input logic rpw);
        exp_t e;
        e.busy_len = len; e.nxm = m_nxm; e.par = m_par; e.apar = m_apar;
        e.rpw = rpw; e.hold = m_hold; e.ewr = m_ewr; e.rerr = m_rerr;
        e.eadr = m_eadr; e.esrc = m_esrc;
        sb_q.push_back(e);
    endfunction

    // Each falling edge of core_busy closes one scoreboard entry.
    int busy_run = 0;
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (RESET) begin
            busy_run = 0;
            busy_prev = 1'b0;
        end else begin
            if (core_busy) begin
                busy_run++;
            end else if (busy_prev) begin
                chk("sb_pending", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("busy_len", busy_run, e.busy_len);
                    chk("nxm_err", nxm_err, e.nxm);
                    chk("par_err", par_err, e.par);
                    chk("adr_par_err", adr_par_err, e.apar);
                    chk("rd_pse_wr", rd_pse_wr, e.rpw);
                    chk("err_hold", err_hold, e.hold);
                    chk("req_err", req_err, e.rerr);
                    if (e.hold) begin
                        chk("era_adr", era_adr, e.eadr);
                        chk("era_src", era_src, e.esrc);
                        chk("era_wr", era_wr, e.ewr);
                    end
                end
                busy_run = 0;
            end
            busy_prev = core_busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] s, input logic [ADR_W-1:0] a, input logic rd, input logic wr);
        mem_start = 1; req_src = s; req_adr = a; req_rd = rd; req_wr = wr;
        tick();
        mem_start = 0; req_src = 2'($urandom); req_adr = ADR_W'($urandom);
        req_rd = 0; req_wr = 0;
    endtask

    task automatic do_write(input logic [1:0] s, input logic [ADR_W-1:0] a, input int gap,
                            input logic par_ok, input logic apar, input logic clr);
        if (clr) m_clear();
        if (!par_ok) m_err(1, s, a, 1);
        if (apar) m_err(2, s, a, 1);
        push(gap + 1, 0);
        start(s, a, 0, 1);
        repeat (gap) tick();
        ackn_pulse = 1; mb_par_odd = par_ok; mem_adr_par_err = apar; err_clr = clr;
        tick();
        ackn_pulse = 0; mb_par_odd = 1; mem_adr_par_err = 0; err_clr = 0;
    endtask

    task automatic do_read(input logic [1:0] s, input logic [ADR_W-1:0] a, input int ag, input int dg,
                           input logic par_ok, input logic rpw);
        if (!par_ok) m_err(1, s, a, 0);
        push(ag + dg + 2, rpw);
        start(s, a, 1, rpw);
        repeat (ag) tick();
        ackn_pulse = 1;
        tick();
        ackn_pulse = 0;
        repeat (dg) tick();
        mem_data_val = 1; mb_par_odd = par_ok;
        tick();
        mem_data_val = 0; mb_par_odd = 1;
    endtask

    task automatic do_wr2(input logic [1:0] s, input logic [ADR_W-1:0] a, input int gap, input logic par_ok);
        if (!par_ok) m_err(1, s, a, 1);
        push(gap + 1, 0);
        start(~s, ~a, 0, 1);
        repeat (gap) tick();
        ackn_pulse = 1; mb_par_odd = par_ok;
        tick();
        ackn_pulse = 0; mb_par_odd = 1;
    endtask

    task automatic do_nxm(input logic [1:0] s, input logic [ADR_W-1:0] a, input logic rd);
        int c, ack_at, dv_at, n_ack, n_dv;
        m_err(0, s, a, ~rd);
        push(LIM + TAIL + 1, 0);
        start(s, a, rd, ~rd);
        ack_at = -1; dv_at = -1; n_ack = 0; n_dv = 0;
        for (c = 0; c <= 400; c++) begin
            @(negedge clk);
            if (nxm_ack) begin n_ack++; ack_at = c; end
            if (nxm_data_val) begin n_dv++; dv_at = c; end
            if (!core_busy) break;
            tick();
        end
        chk("nxm_ack_cycle", ack_at, LIM);
        chk("nxm_ack_count", n_ack, 1);
        chk("nxm_dv_cycle", dv_at, rd ? LIM + 1 : -1);
        chk("nxm_dv_count", n_dv, rd ? 1 : 0);
        chk("nxm_busy_end", c, LIM + TAIL + 1);
        tick();
    endtask

    task automatic clear_errs();
        m_clear();
        err_clr = 1;
        tick();
        err_clr = 0;
        @(negedge clk);
        chk("clr_flags", {nxm_err, par_err, adr_par_err, sbus_err, err_hold}, 0);
        chk("clr_req_err", req_err, 0);
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {core_busy, nxm_ack, nxm_data_val, rd_pse_wr}, 0);
        chk({tag, "_flags"}, {nxm_err, par_err, adr_par_err, sbus_err, err_hold}, 0);
        chk({tag, "_req_err"}, req_err, 0);
        chk({tag, "_era"}, {era_adr, era_src, era_wr}, 0);
    endtask

    initial begin
        int n_ack;
        int n_busy;
        RESET = 1; mem_start = 0; req_src = 0; req_rd = 0; req_wr = 0; req_adr = '0;
        ackn_pulse = 0; mem_data_val = 0; mb_par_odd = 1; mem_adr_par_err = 0;
        sbus_err_in = 0; err_clr = 0;
        m_clear(); m_eadr = '0; m_esrc = '0; m_ewr = 0;
        repeat (3) tick();
        RESET = 0;
        @(negedge clk);
        chk_all_zero("reset");
        tick();

        do_write(2'd2, 22'h12345, 5, 1, 0, 0);
        repeat (2) tick();

        do_nxm(2'd1, 22'h3FFFFF, 1);
        clear_errs();

        do_read(2'd3, 22'h00ABC, 2, 3, 0, 0);
        repeat (2) tick();
        do_nxm(2'd0, 22'h2AAAA, 1);

        do_write(2'd2, 22'h11111, 3, 1, 1, 1);
        repeat (2) tick();
        chk("clr_apar_others", {nxm_err, par_err}, 0);

        sbus_err_in = 1;
        tick();
        sbus_err_in = 0;
        @(negedge clk);
        chk("sbus_set", sbus_err, 1);
        chk("sbus_era_kept", era_adr, 22'h11111);
        tick();
        clear_errs();

        do_read(2'd0, 22'h05555, 1, 1, 1, 1);
        repeat (3) tick();
        @(negedge clk);
        chk("rpw_hold", {rd_pse_wr, core_busy}, 2'b10);
        tick();
        do_wr2(2'd0, 22'h05555, 1, 1);
        repeat (2) tick();

        do_read(2'd1, 22'h0F0F0, 0, 0, 1, 1);
        tick();
        do_wr2(2'd1, 22'h0F0F0, 2, 0);
        repeat (2) tick();
        clear_errs();

        do_write(2'd3, 22'h00777, LIM - 1, 1, 0, 0);
        repeat (2) tick();

        do_read(2'd2, 22'h1ABCD, 0, 2, 0, 1);
        tick();
        RESET = 1;
        m_clear(); m_eadr = '0; m_esrc = '0; m_ewr = 0;
        #2;
        chk_all_zero("rst_wait_wr");
        tick();
        RESET = 0;
        n_ack = 0; n_busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (nxm_ack) n_ack++;
            if (core_busy) n_busy++;
            tick();
        end
        chk("rst_no_nxm_ack", n_ack, 0);
        chk("rst_no_busy", n_busy, 0);
        chk("rst_rpw_clear", rd_pse_wr, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
